// File: rtl/store_merge_unit.sv
// store_merge_unit
// Read-modify-write store engine sitting between the MEM stage and a data
// memory whose write port only takes full words. Sub-word stores read the
// containing word, merge the new bytes little-endian and write the word back;
// full-word stores are written directly. Misaligned addresses, illegal store
// types and read timeouts are reported through the completion status.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   st_valid / st_ready   store request handshake (ready only while idle)
//   st_addr, st_data      byte address, right-justified store data
//   st_type               0=SB 1=SH 2=SW 3=SD (SD only legal for 64-bit words)
//   st_done, st_exc       one-cycle completion pulse and its cause
//                         (0 ok, 1 misaligned, 2 illegal type, 3 read timeout)
//   mem_addr              word-aligned memory address
//   mem_re                one-cycle read request
//   mem_rvalid, mem_rdata read response
//   mem_we, mem_wdata     one-cycle full-word write
module store_merge_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_type,
    output logic              st_done,
    output logic [1:0]        st_exc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [7:0] TIMEOUT_LIM = 8'(RD_TIMEOUT);

    localparam logic [1:0] EXC_OK       = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WRITE   = 3'd3,
        S_REPORT  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        exc_s;
    logic [ADDR_W-1:0] addr_r;
    logic [OFF_W-1:0]  off_r;
    logic [3:0]        bytes_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] wdata_r;
    logic [7:0]        cnt_r;
    logic [1:0]        exc_r;

    logic [3:0]        req_bytes_s;
    logic [3:0]        req_off_s;
    logic              req_illegal_s;
    logic              req_misalign_s;
    logic              req_full_s;

    // Number of bytes written by a store type.
    function automatic logic [3:0] store_bytes(input logic [1:0] typ);
        case (typ)
            2'd0:    store_bytes = 4'd1;
            2'd1:    store_bytes = 4'd2;
            2'd2:    store_bytes = 4'd4;
            default: store_bytes = 4'd8;
        endcase
    endfunction

    // Lanes off..off+nbytes-1 take the low store bytes, the rest keep memory.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] rdata,
        input logic [DATA_W-1:0] sdata,
        input logic [OFF_W-1:0]  off,
        input logic [3:0]        nbytes
    );
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] result;
        shifted = sdata << {off, 3'b000};
        result  = rdata;
        for (int i = 0; i < BYTES; i++) begin
            if ((i >= int'(off)) && (i < int'(off) + int'(nbytes))) begin
                result[8*i +: 8] = shifted[8*i +: 8];
            end else begin
                result[8*i +: 8] = rdata[8*i +: 8];
            end
        end
        merge_word = result;
    endfunction

    // Classify the request presented on the store port.
    always_comb begin
        req_bytes_s    = store_bytes(st_type);
        req_off_s      = 4'(st_addr[OFF_W-1:0]);
        req_illegal_s  = (st_type == 2'd3) && (BYTES == 4);
        req_misalign_s = (req_off_s & (req_bytes_s - 4'd1)) != 4'd0;
        req_full_s     = (req_bytes_s == 4'(BYTES));
    end

    // Next-state logic; illegal type is checked before misalignment.
    always_comb begin
        state_s = state_r;
        exc_s   = EXC_OK;
        case (state_r)
            S_IDLE: begin
                if (st_valid) begin
                    if (req_illegal_s) begin
                        state_s = S_REPORT;
                        exc_s   = EXC_ILLEGAL;
                    end else if (req_misalign_s) begin
                        state_s = S_REPORT;
                        exc_s   = EXC_MISALIGN;
                    end else if (req_full_s) begin
                        state_s = S_WRITE;
                    end else begin
                        state_s = S_RD_REQ;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_REQ: state_s = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    state_s = S_WRITE;
                end else if (cnt_r >= TIMEOUT_LIM) begin
                    state_s = S_REPORT;
                end else begin
                    state_s = S_RD_WAIT;
                end
            end
            S_WRITE:  state_s = S_IDLE;
            S_REPORT: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State register plus request, merge, timeout and cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            addr_r  <= '0;
            off_r   <= '0;
            bytes_r <= 4'd0;
            data_r  <= '0;
            wdata_r <= '0;
            cnt_r   <= 8'd0;
            exc_r   <= EXC_OK;
        end else begin
            state_r <= state_s;
            case (state_r)
                S_IDLE: begin
                    if (st_valid) begin
                        addr_r  <= {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        off_r   <= st_addr[OFF_W-1:0];
                        bytes_r <= req_bytes_s;
                        data_r  <= st_data;
                        exc_r   <= exc_s;
                        cnt_r   <= 8'd0;
                        if (state_s == S_WRITE) begin
                            wdata_r <= st_data;
                        end
                    end
                end
                S_RD_REQ: cnt_r <= 8'd0;
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        wdata_r <= merge_word(mem_rdata, data_r, off_r, bytes_r);
                    end else if (cnt_r >= TIMEOUT_LIM) begin
                        exc_r <= EXC_TIMEOUT;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state.
    assign st_ready  = (state_r == S_IDLE);
    assign mem_re    = (state_r == S_RD_REQ);
    assign mem_we    = (state_r == S_WRITE);
    assign st_done   = (state_r == S_WRITE) || (state_r == S_REPORT);
    assign st_exc    = (state_r == S_REPORT) ? exc_r : EXC_OK;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_store_merge_unit.sv
`timescale 1ns/1ps
module tb_store_merge_unit;
    localparam int RT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-bit instance (scoreboarded)
    logic        rst_n, st_valid, st_ready, st_done, mem_re, mem_we, mem_rvalid;
    logic [31:0] st_addr, st_data, mem_addr, mem_rdata, mem_wdata;
    logic [1:0]  st_type, st_exc;

    // 64-bit instance (directed)
    logic        w_st_valid, w_st_ready, w_st_done, w_mem_re, w_mem_we, w_mem_rvalid;
    logic [31:0] w_st_addr, w_mem_addr;
    logic [63:0] w_st_data, w_mem_rdata, w_mem_wdata;
    logic [1:0]  w_st_type, w_st_exc;

    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RD_TIMEOUT(RT)) u32 (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
        .st_done(st_done), .st_exc(st_exc), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_wdata(mem_wdata)
    );

    store_merge_unit #(.DATA_W(64), .ADDR_W(32), .RD_TIMEOUT(RT)) u64 (
        .clk(clk), .rst_n(rst_n), .st_valid(w_st_valid), .st_ready(w_st_ready),
        .st_addr(w_st_addr), .st_data(w_st_data), .st_type(w_st_type),
        .st_done(w_st_done), .st_exc(w_st_exc), .mem_addr(w_mem_addr), .mem_re(w_mem_re),
        .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata), .mem_we(w_mem_we),
        .mem_wdata(w_mem_wdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected completion of one accepted store.
    typedef struct {
        logic [1:0]  exc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          re_cyc;
        int          done_cyc;
    } exp_t;
    exp_t q[$];

    // Reference memory: byte addressed, untouched bytes follow a fixed pattern.
    logic [7:0]  ref_mem [int];
    // Bench memory behind the DUT's port, word addressed.
    logic [31:0] bmem [int];

    function automatic logic [7:0] pat(int a);
        return 8'((a * 37 + 90) & 255);
    endfunction

    function automatic logic [7:0] ref_byte(int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pat(a);
    endfunction

    function automatic logic [31:0] ref_word(int wa);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_byte(wa + b);
        return w;
    endfunction

    function automatic logic [31:0] bench_word(int wa);
        logic [31:0] w;
        if (bmem.exists(wa)) return bmem[wa];
        for (int b = 0; b < 4; b++) w[8*b +: 8] = pat(wa + b);
        return w;
    endfunction

    task automatic preload(int wa, logic [31:0] w);
        bmem[wa] = w;
        for (int b = 0; b < 4; b++) ref_mem[wa + b] = w[8*b +: 8];
    endtask

    // Memory responder: answers mem_re after rsp_delay cycles, captures writes.
    int          rsp_delay = 1;
    int          rsp_cnt;
    logic        rsp_busy;
    logic [31:0] rsp_addr;
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        rsp_busy   = 1'b0;
        rsp_cnt    = 0;
        rsp_addr   = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                rsp_busy = 1'b0;
            end else begin
                if (mem_we) bmem[int'(mem_addr)] = mem_wdata;
                if (rsp_busy) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = bench_word(int'(rsp_addr));
                        rsp_busy   = 1'b0;
                    end
                end
                if (mem_re) begin
                    rsp_busy = 1'b1;
                    rsp_cnt  = rsp_delay;
                    rsp_addr = mem_addr;
                end
            end
        end
    end

    // Monitor: pops the expected completion whenever the DUT reports one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
            end else begin
                if (mem_re) begin
                    chk("re_expected", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) chk("re_cycle", 64'(q[0].re_cyc), 64'(cyc));
                end
                if (mem_we && !st_done) chk("we_with_done", 64'(st_done), 64'd1);
                if (st_done) begin
                    chk("done_expected", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        chk("st_exc", 64'(st_exc), 64'(e.exc));
                        chk("mem_we", 64'(mem_we), 64'(e.we));
                        if (e.we) begin
                            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                            chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                        end
                    end
                end
            end
        end
    end

    // Issue one store to the 32-bit unit; d = cycles from mem_re to mem_rvalid.
    task automatic issue(int addr, logic [31:0] data, logic [1:0] typ, int d);
        exp_t e;
        int   nb;
        int   guard;
        guard = 0;
        if (typ != 2'd2) begin
            while (rsp_busy && guard < 64) begin @(negedge clk); guard++; end
        end
        guard = 0;
        while (st_ready !== 1'b1 && guard < 64) begin @(negedge clk); guard++; end
        chk("ready_before_issue", 64'(st_ready), 64'd1);
        nb       = 1 << typ;
        e.exc    = 2'd0;
        e.we     = 1'b0;
        e.addr   = 32'(addr) & 32'hFFFF_FFFC;
        e.wdata  = 32'd0;
        e.re_cyc = -1;
        if (typ == 2'd3) begin
            e.exc = 2'd2; e.done_cyc = cyc + 1;
        end else if ((addr % nb) != 0) begin
            e.exc = 2'd1; e.done_cyc = cyc + 1;
        end else begin
            if (nb != 4) e.re_cyc = cyc + 1;
            if (nb != 4 && d >= RT + 2) begin
                e.exc = 2'd3; e.done_cyc = cyc + 3 + RT;
            end else begin
                for (int b = 0; b < nb; b++) ref_mem[addr + b] = data[8*b +: 8];
                e.we       = 1'b1;
                e.wdata    = ref_word(int'(e.addr));
                e.done_cyc = (nb == 4) ? cyc + 1 : cyc + 2 + d;
            end
        end
        rsp_delay = d;
        q.push_back(e);
        st_valid = 1'b1; st_addr = 32'(addr); st_data = data; st_type = typ;
        @(negedge clk);
        st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_type = 2'($urandom);
    endtask

    // Directed store to the 64-bit unit with fixed response one cycle after mem_re.
    task automatic w_run(logic [31:0] addr, logic [63:0] data, logic [1:0] typ,
                         logic [63:0] rd, logic sub, logic [1:0] exp_exc,
                         logic [31:0] exp_addr, logic [63:0] exp_wd);
        chk("w_ready", 64'(w_st_ready), 64'd1);
        w_st_valid = 1'b1; w_st_addr = addr; w_st_data = data; w_st_type = typ;
        @(negedge clk);
        w_st_valid = 1'b0;
        if (sub) begin
            chk("w_re", 64'(w_mem_re), 64'd1);
            chk("w_rd_addr", 64'(w_mem_addr), 64'(exp_addr));
            @(negedge clk);
            w_mem_rvalid = 1'b1; w_mem_rdata = rd;
            @(negedge clk);
            w_mem_rvalid = 1'b0;
        end
        chk("w_done", 64'(w_st_done), 64'd1);
        chk("w_exc", 64'(w_st_exc), 64'(exp_exc));
        chk("w_we", 64'(w_mem_we), 64'(exp_exc == 2'd0));
        if (exp_exc == 2'd0) begin
            chk("w_addr", 64'(w_mem_addr), 64'(exp_addr));
            chk("w_wdata", w_mem_wdata, exp_wd);
        end
        @(negedge clk);
    endtask

    initial begin
        int          addr;
        int          nb;
        int          guard;
        logic [1:0]  typ;
        rst_n = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_type = 2'd0;
        w_st_valid = 1'b0; w_st_addr = '0; w_st_data = '0; w_st_type = 2'd0;
        w_mem_rvalid = 1'b0; w_mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", 64'(st_done), 64'd0);
        chk("rst_exc", 64'(st_exc), 64'd0);
        chk("rst_re", 64'(mem_re), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(st_ready), 64'd1);

        // Sub-byte merge into a known word, then a plain full-word store.
        preload(32'h100, 32'h11223344);
        issue(32'h103, 32'h000000AA, 2'd0, 1);
        issue(32'h100, 32'hDEADBEEF, 2'd2, 1);
        // Exceptions: misaligned SH, SD illegal (with and without misalignment).
        issue(32'h101, 32'h0000BEEF, 2'd1, 1);
        issue(32'h105, 32'h12345678, 2'd3, 1);
        issue(32'h108, 32'h12345678, 2'd3, 1);
        // Response in the last RD_WAIT cycle is still taken.
        issue(32'h10A, 32'h00007788, 2'd1, RT + 1);
        // Timeout with a late response landing on the following full-word write.
        issue(32'h10C, 32'h0000005C, 2'd0, RT + 4);
        issue(32'h110, 32'hCAFEF00D, 2'd2, 1);

        // Reset abort during RD_WAIT.
        issue(32'h114, 32'h00000077, 2'd0, RT + 4);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_done", 64'(st_done), 64'd0);
        chk("abort_we", 64'(mem_we), 64'd0);
        chk("abort_re", 64'(mem_re), 64'd0);
        chk("abort_addr", 64'(mem_addr), 64'd0);
        chk("abort_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 64'(st_ready), 64'd1);
        chk("abort_exc", 64'(st_exc), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            typ  = 2'($urandom_range(0, 3));
            nb   = 1 << typ;
            addr = 32'h100 + $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(nb - 1);
            issue(addr, $urandom, typ, $urandom_range(1, RT + 4));
        end

        // 64-bit unit: SH merge, SW merge, SD full word, exceptions.
        w_run(32'h206, 64'h000000000000BEEF, 2'd1, 64'h0123456789ABCDEF, 1'b1,
              2'd0, 32'h200, 64'hBEEF456789ABCDEF);
        w_run(32'h204, 64'hFFFFFFFF11223344, 2'd2, 64'h0123456789ABCDEF, 1'b1,
              2'd0, 32'h200, 64'h1122334489ABCDEF);
        w_run(32'h20B, 64'h00000000000000A5, 2'd0, 64'h0011223344556677, 1'b1,
              2'd0, 32'h208, 64'h00112233A5556677);
        w_run(32'h208, 64'h8877665544332211, 2'd3, 64'd0, 1'b0,
              2'd0, 32'h208, 64'h8877665544332211);
        w_run(32'h202, 64'h0, 2'd2, 64'd0, 1'b0, 2'd1, 32'h0, 64'h0);
        w_run(32'h20C, 64'h0, 2'd3, 64'd0, 1'b0, 2'd1, 32'h0, 64'h0);

        guard = 0;
        while (q.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
